// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port RAM arbiter for CPU fetch and data ports, data
//            priority with a fetch starvation guard, registered read data.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_lat_cnt;
    logic [3:0]        r_starve_cnt;
    logic              r_gnt_d;
    logic              r_gnt_we;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_issue;
    logic              w_pick_d;
    logic              w_contested;

    always_comb begin
        w_next_state = r_state;
        w_contested  = if_req && d_req;
        w_pick_d     = d_req && !(w_contested && (r_starve_cnt == c_STARVE_MAX));
        w_issue      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Issue is suppressed under reset so the strobe never leaks
                if (!sys_rst && (if_req || d_req)) begin
                    w_issue      = 1'b1;
                    mem_en       = 1'b1;
                    mem_we       = w_pick_d && d_we;
                    mem_addr     = w_pick_d ? d_addr : if_addr;
                    mem_wdata    = w_pick_d ? d_wdata : '0;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                d_done       = r_gnt_d && !sys_rst;
                if_done      = !r_gnt_d && !sys_rst;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= 3'd0;
            r_starve_cnt <= 4'd0;
            r_gnt_d      <= 1'b0;
            r_gnt_we     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_gnt_d   <= w_pick_d;
                        r_gnt_we  <= w_pick_d && d_we;
                        r_lat_cnt <= c_LAT_INIT;
                        // Only a data win over a waiting fetch counts toward starvation
                        if (w_pick_d && w_contested) begin
                            if (r_starve_cnt != c_STARVE_MAX) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_starve_cnt <= 4'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt != 3'd0) begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end else if (r_gnt_d) begin
                        if (!r_gnt_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end else begin
                        r_if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Randomized scoreboard bench for mem_arbiter with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int SMAX  = 4;
    localparam int N_CYC = 3000;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          if_req, d_req, d_we;
    logic          if_done, d_done, mem_en, mem_we;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // RAM: read data appears LAT cycles after the strobe, junk otherwise
    logic          init_fill;
    logic [DW-1:0] ram  [0:63];
    logic [DW-1:0] pipe [0:LAT-1];

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h2002_0005 ^ (32'(i) * 32'h0101_0107);
    endfunction

    always @(posedge sys_clk) begin
        if (init_fill) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
        pipe[0] <= mem_en ? ram[mem_addr[7:2]] : $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;
    typedef struct { int cyc; logic port_d; logic [DW-1:0] exp_if; logic [DW-1:0] exp_d; } done_t;

    iss_t  iq[$];
    done_t dq[$];
    iss_t  mi;
    done_t md;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: compares every observed strobe and done pulse with the queues
    always @(negedge sys_clk) begin
        if (mem_en) begin
            if (iq.size() == 0) begin
                chk("unexpected_issue", mem_en, 1'b0);
            end else begin
                mi = iq.pop_front();
                chk("issue_cycle", cyc, mi.cyc);
                chk("mem_we", mem_we, mi.we);
                chk("mem_addr", mem_addr, mi.addr);
                if (mi.we) chk("mem_wdata", mem_wdata, mi.wdata);
            end
        end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
            mi = iq.pop_front();
            chk("issue_missing", mem_en, 1'b1);
        end
        if (if_done && d_done) chk("done_exclusive", {if_done, d_done}, 2'b01);
        if (if_done || d_done) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", {if_done, d_done}, 2'b00);
            end else begin
                md = dq.pop_front();
                chk("done_cycle", cyc, md.cyc);
                chk("done_port", d_done, md.port_d);
                chk("if_rdata", if_rdata, md.exp_if);
                chk("d_rdata", d_rdata, md.exp_d);
            end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            md = dq.pop_front();
            chk("done_missing", if_done || d_done, 1'b1);
        end
    end

    // Reference model and requester state
    logic [DW-1:0] mref [0:63];
    logic          fa, da, dwe_r, m_busy, m_port_d, win_d;
    logic [AW-1:0] fad, dad;
    logic [DW-1:0] dwd, exp_if, exp_d;
    int            m_idle_cyc, m_done_cyc, m_starve;

    task automatic new_f();
        fa  = 1'b1;
        fad = 32'($urandom_range(0, 31)) << 2;
    endtask

    task automatic new_d();
        da    = 1'b1;
        dad   = 32'($urandom_range(32, 63)) << 2;
        dwd   = $urandom;
        dwe_r = 1'($urandom_range(0, 1));
    endtask

    task automatic drive();
        if_req  = fa;
        if_addr = fad;
        d_req   = da;
        d_we    = dwe_r;
        d_addr  = dad;
        d_wdata = dwd;
    endtask

    initial begin
        int c, rst_at, quiet_until, post_chk, p_start, p_re;
        logic mid_armed;
        for (int i = 0; i < 64; i++) mref[i] = init_word(i);
        init_fill = 1'b1;
        sys_rst = 1'b1;
        fa = 1'b0; da = 1'b0; dwe_r = 1'b0; fad = '0; dad = '0; dwd = '0;
        drive();
        repeat (3) @(posedge sys_clk);
        #2;
        chk("reset_mem_en", mem_en, 1'b0);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_done", {if_done, d_done}, 2'b00);
        chk("reset_if_rdata", if_rdata, '0);
        chk("reset_d_rdata", d_rdata, '0);
        init_fill = 1'b0;
        m_busy = 1'b0; m_port_d = 1'b0; m_idle_cyc = 0; m_done_cyc = -1; m_starve = 0;
        exp_if = '0; exp_d = '0;
        rst_at = -10; quiet_until = -10; post_chk = -10; mid_armed = 1'b0;

        for (int n = 0; n < N_CYC; n++) begin
            @(posedge sys_clk); #1;
            c       = cyc;
            p_start = (n < 600) ? 100 : 30;
            p_re    = (n >= N_CYC - 40) ? 0 : ((n < 600) ? 100 : 50);
            if (n == 1500) mid_armed = 1'b1;

            if (c == rst_at || n == 2600) begin
                sys_rst = 1'b1;
                if (c == rst_at) begin
                    fa = 1'b0; da = 1'b0; quiet_until = c + 1;
                end
                drive();
                iq.delete(); dq.delete();
                m_busy = 1'b0; m_idle_cyc = c + 1; m_starve = 0;
                exp_if = '0; exp_d = '0; post_chk = c + 1;
                #1;
                chk("rst_cycle_mem_en", mem_en, 1'b0);
                chk("rst_cycle_done", {if_done, d_done}, 2'b00);
                continue;
            end
            sys_rst = 1'b0;

            if (c == post_chk) begin
                chk("post_rst_if_rdata", if_rdata, '0);
                chk("post_rst_d_rdata", d_rdata, '0);
                if (c == quiet_until) chk("post_rst_mem_en", mem_en, 1'b0);
            end

            // Requester reacts during DONE: drop or replace its request
            if (m_busy && c == m_done_cyc) begin
                m_busy = 1'b0;
                if (m_port_d) begin
                    da = 1'b0;
                    if ($urandom_range(1, 100) <= p_re) new_d();
                end else begin
                    fa = 1'b0;
                    if ($urandom_range(1, 100) <= p_re) new_f();
                end
            end
            if (c == quiet_until + 1) new_f();
            if (c > quiet_until && n < N_CYC - 40) begin
                if (!fa && $urandom_range(1, 100) <= p_start) new_f();
                if (!da && $urandom_range(1, 100) <= p_start) new_d();
            end
            drive();

            if (c >= m_idle_cyc && (fa || da)) begin
                win_d = da && !(fa && m_starve == SMAX);
                if (win_d && fa) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                else m_starve = 0;
                if (win_d) begin
                    iq.push_back('{c, dwe_r, dad, dwd});
                    if (dwe_r) mref[dad[7:2]] = dwd;
                    else exp_d = mref[dad[7:2]];
                end else begin
                    iq.push_back('{c, 1'b0, fad, '0});
                    exp_if = mref[fad[7:2]];
                end
                dq.push_back('{c + LAT + 1, win_d, exp_if, exp_d});
                m_busy = 1'b1; m_port_d = win_d;
                m_done_cyc = c + LAT + 1; m_idle_cyc = c + LAT + 2;
                if (mid_armed) begin
                    rst_at = c + 1; mid_armed = 1'b0;
                end
            end
        end

        repeat (LAT + 4) @(posedge sys_clk);
        #1;
        chk("issues_outstanding", 64'(iq.size()), 64'd0);
        chk("dones_outstanding", 64'(dq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the CPU's instruction-fetch port and data port, and one unified synchronous-read RAM. It serialises both requesters onto the RAM, counts the RAM read latency, and returns per-port completion pulses with registered read data. Fixed priority goes to the data port, with a starvation guard for fetch. The CPU holds its PC and register write-back while either of its requests is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32: address width, byte address passed through unchanged.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: RAM read latency in cycles, from `mem_en` to valid `mem_rdata`. Legal range 1..7.
- `STARVE_MAX`, 4: number of consecutive contested data wins after which fetch is forced. Legal range 1..15.

Ports:
- `sys_clk`  in  1  clock, rising edge.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `if_req`  in  1  fetch request, held high until `if_done`.
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req` is high.
- `if_rdata`  out  DATA_W  registered fetch data.
- `if_done`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request, held high until `d_done`.
- `d_we`  in  1  1 = write, 0 = read; stable while `d_req` is high.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_rdata`  out  DATA_W  registered load data.
- `d_done`  out  1  one-cycle data completion pulse.
- `mem_en`  out  1  RAM access strobe, one cycle per transaction.
- `mem_we`  out  1  RAM write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid MEM_LAT cycles after `mem_en`.

## Operation
- **FSM states:** IDLE, WAIT, DONE. At most one transaction is in flight.
- **IDLE with any request pending:** arbitrate and issue in the same cycle. The `mem_*` outputs are combinational from the grant: `mem_en`=1, and addr/we/wdata are taken from the winner. Fetch always drives `mem_we`=0.
  - Record the winner in `gnt_d` (1 = data).
  - Load the latency counter with MEM_LAT-1.
  - Next state is WAIT.
- **IDLE with no request:** `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata`=0. Stay in IDLE.
- **Arbitration rules:**
  - Only data requesting: data wins.
  - Only fetch requesting: fetch wins.
  - Both requesting: data wins unless `starve_cnt`==STARVE_MAX, in which case fetch wins.
- **starve_cnt updates, at each issue:**
  - Contested data win: increment, saturating at STARVE_MAX.
  - Fetch win: clear.
  - Uncontested data win: clear.
- **WAIT:** `mem_en`=0.
  - If the counter is non-zero, decrement it.
  - When the counter is 0, `mem_rdata` is valid. Capture it into `d_rdata` (read, `gnt_d`=1) or `if_rdata` (`gnt_d`=0) and go to DONE.
  - Data writes capture nothing; `d_rdata` holds its previous value.
- **DONE:** assert `d_done` or `if_done` (per `gnt_d`) for exactly this cycle, then go to IDLE.
  - No issue happens in DONE.
  - The requester drops or replaces its request during DONE.
- `if_rdata` and `d_rdata` hold their value until the next read completion on the same port.
- Requests and input changes arriving during WAIT or DONE are ignored. They are sampled only in IDLE.
- **Reset:** on `sys_rst`, the next state is IDLE.
  - `starve_cnt`, latency counter, `gnt_d` cleared to 0.
  - `if_rdata`, `d_rdata` cleared to 0.
  - Any in-flight transaction is abandoned and produces no done pulse.
  - A write already issued to the RAM is not undone.

## Timing
- **Reset values:** `if_done`=`d_done`=0, `if_rdata`=`d_rdata`=0. `mem_en`=0 and `mem_we`=0 in the reset cycle and after it, until a request is seen in IDLE.
- **Latency:** request seen in IDLE at cycle t → `mem_en` at t → capture at t+MEM_LAT → done pulse at t+MEM_LAT+1 → IDLE at t+MEM_LAT+2.
  - Earliest back-to-back issue is t+MEM_LAT+2, i.e. one transaction per MEM_LAT+2 cycles.
  - Writes take the same latency as reads.
- **Done pulses:** `if_done` and `d_done` are never high together. Each is high for exactly one cycle per issued transaction.
- **Simultaneous reset and done:** reset wins; no pulse.
- **Counter width:** the latency counter is 3 bits and `starve_cnt` is 4 bits. No wrap occurs within the legal parameter ranges.

## Test plan
- **Fetch read, MEM_LAT=1:** RAM word @0x04=0x2002_0005; `if_req` high with `if_addr`=0x04 in IDLE at cycle 0 → `mem_en`=1, `mem_addr`=0x04 at cycle 0; `if_done`=1 and `if_rdata`=0x2002_0005 at cycle 2; `d_done` stays 0.
- **Data write then read, MEM_LAT=3:** write 0xDEAD_BEEF @0x40 → `mem_we`=1 for 1 cycle, `d_done` 4 cycles after issue, `d_rdata` unchanged; then read @0x40 → `d_rdata`=0xDEAD_BEEF, issued no earlier than 5 cycles after the first issue.
- **Contention with starvation guard, STARVE_MAX=4:** `if_req` and `d_req` both held high; data re-requests in each DONE → grant order D,D,D,D,F,D,…; `starve_cnt` returns to 0 after the fetch grant.
- **Fetch-only and data-only alternation:** priority is never exercised and `starve_cnt` stays 0; each done pulse maps to the correct port and rdata register.
- **Reset mid-WAIT, MEM_LAT=3:** assert `sys_rst` one cycle after issue → no done pulse; both rdata=0; `mem_en`=0 the following cycle; a new `if_req` completes normally.
- **Request held through DONE, then dropped in DONE:** no duplicate issue; `mem_en` stays 0 until a fresh request is seen in IDLE.
